instr_decode_stage: RTL

- Decode-stage pipeline buffer between instruction fetch and the immediate extender / register file.
- Accepts fetched 32-bit instruction words with PC over a valid/ready handshake.
- Holds them in a 2-entry skid buffer and presents the split fields downstream: opcode, rd, rs1, rs2, imm16, type class.
- Downstream uses these fields to form the 32-bit immediate and read operands.

---
 rtl/cpu_decode_pkg.sv | 52 +++++
 rtl/instr_decode_stage_skid_buffer2.sv | 92 +++++++++
 rtl/instr_decode_stage.sv | 75 +++++++
 3 files changed

// File: rtl/cpu_decode_pkg.sv
// Shared decode definitions: instruction field positions, type classes and the
// decoded-instruction payload carried through the decode-stage buffer.
package cpu_decode_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned PC_WIDTH    = 32;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RD_HI  = 25;
  localparam int unsigned RD_LO  = 22;
  localparam int unsigned RS1_HI = 21;
  localparam int unsigned RS1_LO = 18;
  localparam int unsigned RS2_HI = 17;
  localparam int unsigned RS2_LO = 14;
  localparam int unsigned IMM_HI = 17;
  localparam int unsigned IMM_LO = 2;

  localparam int unsigned OPC_W = OPC_HI - OPC_LO + 1;
  localparam int unsigned REG_W = RD_HI - RD_LO + 1;
  localparam int unsigned IMM_W = IMM_HI - IMM_LO + 1;

  // Inclusive upper opcode bound of each class; S takes everything above J.
  localparam int unsigned OPC_R_MAX = 7;
  localparam int unsigned OPC_I_MAX = 23;
  localparam int unsigned OPC_J_MAX = 27;

  typedef enum logic [1:0] {
    ITYPE_R = 2'b00,
    ITYPE_I = 2'b01,
    ITYPE_J = 2'b10,
    ITYPE_S = 2'b11
  } instr_type_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [OPC_W-1:0]    opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [IMM_W-1:0]    imm16;
    instr_type_t         instr_type;
  } decoded_instr_t;

  function automatic instr_type_t classify_opcode(input logic [OPC_W-1:0] opc);
    if (opc <= OPC_W'(OPC_R_MAX))      return ITYPE_R;
    else if (opc <= OPC_W'(OPC_I_MAX)) return ITYPE_I;
    else if (opc <= OPC_W'(OPC_J_MAX)) return ITYPE_J;
    else                               return ITYPE_S;
  endfunction

endpackage

// File: rtl/instr_decode_stage_skid_buffer2.sv
// skid_buffer2: two-entry valid/ready buffer (main M drives outputs, skid S
// holds the younger entry) carrying decoded_instr_t, with synchronous flush.
module skid_buffer2
  import cpu_decode_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  decoded_instr_t in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output decoded_instr_t out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } occ_state_t;

  occ_state_t     r_state;
  occ_state_t     w_state_nxt;
  decoded_instr_t r_m;
  decoded_instr_t r_s;
  decoded_instr_t w_m_nxt;
  decoded_instr_t w_s_nxt;
  logic           r_m_valid;
  logic           r_in_ready;
  logic           w_accept;
  logic           w_drain;

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = r_m_valid && out_ready;

  // Occupancy transitions; flush drops both entries but the drain still happened.
  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_s_nxt     = r_s;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_m_nxt     = in_data;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_drain) begin
            if (w_accept) w_m_nxt = in_data;
            else          w_state_nxt = ST_EMPTY;
          end else if (w_accept) begin
            w_s_nxt     = in_data;
            w_state_nxt = ST_TWO;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            w_m_nxt     = r_s;
            w_state_nxt = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_m        <= '0;
      r_s        <= '0;
      r_m_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_m        <= w_m_nxt;
      r_s        <= w_s_nxt;
      r_m_valid  <= (w_state_nxt != ST_EMPTY);
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_m_valid;
  assign out_data  = r_m;

endmodule

// File: rtl/instr_decode_stage.sv
// Decode-stage pipeline buffer: splits fetched words into fields and buffers them.
// Optional DECODE_ILLEGAL_TRAP_EN flags opcodes >= NUM_OPCODES on out_illegal.
module instr_decode_stage
  import cpu_decode_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
`ifdef DECODE_ILLEGAL_TRAP_EN
  parameter int unsigned NUM_OPCODES = 32,
`endif
  parameter int unsigned PC_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         out_opcode,
  output logic [3:0]         out_rd,
  output logic [3:0]         out_rs1,
  output logic [3:0]         out_rs2,
  output logic [15:0]        out_imm16,
  output logic [1:0]         out_type,
  output logic               out_illegal
);

  decoded_instr_t w_dec;
  decoded_instr_t w_out;
  logic           w_unused_low;

  // Field split and type classification happen before storage.
  always_comb begin
    w_dec            = '0;
    w_dec.pc         = PC_WIDTH'(in_pc);
    w_dec.opcode     = in_instr[OPC_HI:OPC_LO];
    w_dec.rd         = in_instr[RD_HI:RD_LO];
    w_dec.rs1        = in_instr[RS1_HI:RS1_LO];
    w_dec.rs2        = in_instr[RS2_HI:RS2_LO];
    w_dec.imm16      = in_instr[IMM_HI:IMM_LO];
    w_dec.instr_type = classify_opcode(in_instr[OPC_HI:OPC_LO]);
  end

  assign w_unused_low = ^in_instr[IMM_LO-1:0];

  skid_buffer2 u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out)
  );

  assign out_pc     = PC_W'(w_out.pc);
  assign out_opcode = w_out.opcode;
  assign out_rd     = w_out.rd;
  assign out_rs1    = w_out.rs1;
  assign out_rs2    = w_out.rs2;
  assign out_imm16  = w_out.imm16;
  assign out_type   = w_out.instr_type;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign out_illegal = out_valid && (32'(w_out.opcode) >= 32'(NUM_OPCODES));
`else
  assign out_illegal = 1'b0;
`endif

endmodule
